// File: rtl/register_file_param.sv
// Parametrised register file: two registered read ports, one write port,
// write-first bypass, optional hardwired-zero register 0 and a post-reset clear sequencer.
module register_file_param #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 4,
    parameter logic [31:0] IDLE_VAL = 32'h0000FFFF,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dir_a,
    input  logic [ADDR_W-1:0] dir_b,
    input  logic [ADDR_W-1:0] dir_wr,
    input  logic [DATA_W-1:0] di,
    input  logic              re_a,
    input  logic              re_b,
    input  logic              we,
    output logic [DATA_W-1:0] dat_a,
    output logic [DATA_W-1:0] dat_b,
    output logic [DATA_W-1:0] reg_0,
    output logic [DATA_W-1:0] reg_1,
    output logic [DATA_W-1:0] reg_2,
    output logic              ready
);

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] IDLE_W = DATA_W'(IDLE_VAL);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_cnt == '1) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
        end
    end

    assign ready = (state == RUN);

    // Single write port shared by the clear sequencer and user writes; the
    // array itself is not reset, so writes are held off while rst is high.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = dir_wr;
        wr_data = di;
        if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt;
            wr_data = '0;
        end else if (!we && !(ZERO_REG && dir_wr == '0)) begin
            wr_en = 1'b1;
        end
        if (rst) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Write-first bypass; zero-register masking is applied last so it wins.
    always_comb begin
        rd_a = mem[dir_a];
        if (!we && dir_wr == dir_a) begin
            rd_a = di;
        end
        if (ZERO_REG && dir_a == '0) begin
            rd_a = '0;
        end
    end

    always_comb begin
        rd_b = mem[dir_b];
        if (!we && dir_wr == dir_b) begin
            rd_b = di;
        end
        if (ZERO_REG && dir_b == '0) begin
            rd_b = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_a <= IDLE_W;
            dat_b <= IDLE_W;
        end else if (state == CLEAR) begin
            dat_a <= IDLE_W;
            dat_b <= IDLE_W;
        end else begin
            dat_a <= re_a ? IDLE_W : rd_a;
            dat_b <= re_b ? IDLE_W : rd_b;
        end
    end

    assign reg_0 = ZERO_REG ? '0 : mem[0];
    assign reg_1 = mem[1];
    assign reg_2 = mem[2];

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench for register_file_param: one instance without and one with
// the hardwired-zero register, driven identically and checked against a reference model.
module tb_register_file_param;

    localparam logic [31:0] IDLE = 32'h0000FFFF;

    logic        clk;
    logic        rst;
    logic [3:0]  dir_a;
    logic [3:0]  dir_b;
    logic [3:0]  dir_wr;
    logic [31:0] di;
    logic        re_a;
    logic        re_b;
    logic        we;

    logic [31:0] dat_a0, dat_b0, reg0_0, reg1_0, reg2_0;
    logic [31:0] dat_a1, dat_b1, reg0_1, reg1_1, reg2_1;
    logic        ready0, ready1;

    register_file_param #(
        .DATA_W   (32),
        .ADDR_W   (4),
        .IDLE_VAL (32'h0000FFFF),
        .ZERO_REG (1'b0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .dir_a  (dir_a),
        .dir_b  (dir_b),
        .dir_wr (dir_wr),
        .di     (di),
        .re_a   (re_a),
        .re_b   (re_b),
        .we     (we),
        .dat_a  (dat_a0),
        .dat_b  (dat_b0),
        .reg_0  (reg0_0),
        .reg_1  (reg1_0),
        .reg_2  (reg2_0),
        .ready  (ready0)
    );

    register_file_param #(
        .DATA_W   (32),
        .ADDR_W   (4),
        .IDLE_VAL (32'h0000FFFF),
        .ZERO_REG (1'b1)
    ) dut_z (
        .clk    (clk),
        .rst    (rst),
        .dir_a  (dir_a),
        .dir_b  (dir_b),
        .dir_wr (dir_wr),
        .di     (di),
        .re_a   (re_a),
        .re_b   (re_b),
        .we     (we),
        .dat_a  (dat_a1),
        .dat_b  (dat_b1),
        .reg_0  (reg0_1),
        .reg_1  (reg1_1),
        .reg_2  (reg2_1),
        .ready  (ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a [2];
        logic [31:0] b [2];
        logic [31:0] r0 [2];
        logic [31:0] r1 [2];
        logic [31:0] r2 [2];
        logic        rdy;
    } exp_t;

    exp_t        exp_q [$];
    int          errors = 0;
    int          checks = 0;

    // Reference model: word array per instance (X = never written) and
    // the number of clear cycles still owed.
    logic [31:0] mm [2][16];
    int          clr_left = 16;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (!$isunknown(exp)) begin
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
            end
        end
    endtask

    task automatic cyc(input logic r, input logic w, input logic [3:0] wa, input logic [31:0] d,
                       input logic ra, input logic [3:0] aa, input logic rb, input logic [3:0] ab);
        exp_t e;
        @(negedge clk);
        rst = r; we = w; dir_wr = wa; di = d;
        re_a = ra; dir_a = aa; re_b = rb; dir_b = ab;
        for (int z = 0; z < 2; z++) begin
            e.a[z] = IDLE;
            e.b[z] = IDLE;
        end
        if (r) begin
            clr_left = 16;
            e.rdy = 1'b0;
        end else if (clr_left > 0) begin
            for (int z = 0; z < 2; z++) mm[z][16 - clr_left] = '0;
            clr_left--;
            e.rdy = (clr_left == 0);
        end else begin
            for (int z = 0; z < 2; z++) begin
                if (!ra) begin
                    if (z == 1 && aa == 0)   e.a[z] = '0;
                    else if (!w && wa == aa) e.a[z] = d;
                    else                     e.a[z] = mm[z][aa];
                end
                if (!rb) begin
                    if (z == 1 && ab == 0)   e.b[z] = '0;
                    else if (!w && wa == ab) e.b[z] = d;
                    else                     e.b[z] = mm[z][ab];
                end
                if (!w && !(z == 1 && wa == 0)) mm[z][wa] = d;
            end
            e.rdy = 1'b1;
        end
        for (int z = 0; z < 2; z++) begin
            e.r0[z] = (z == 1) ? 32'h0 : mm[z][0];
            e.r1[z] = mm[z][1];
            e.r2[z] = mm[z][2];
        end
        exp_q.push_back(e);
    endtask

    task automatic rnd_cyc();
        logic [3:0] wa;
        logic [3:0] aa;
        logic [3:0] ab;
        wa = 4'($urandom_range(0, 15));
        aa = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
        ab = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
        cyc(1'b0, 1'($urandom_range(0, 1)), wa, $urandom,
            1'($urandom_range(0, 1)), aa, 1'($urandom_range(0, 1)), ab);
    endtask

    // Monitor: outputs are valid every cycle; compare just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ready",   {31'b0, ready0}, {31'b0, e.rdy});
                chk("ready_z", {31'b0, ready1}, {31'b0, e.rdy});
                chk("dat_a",   dat_a0, e.a[0]);
                chk("dat_b",   dat_b0, e.b[0]);
                chk("dat_a_z", dat_a1, e.a[1]);
                chk("dat_b_z", dat_b1, e.b[1]);
                chk("reg_0",   reg0_0, e.r0[0]);
                chk("reg_1",   reg1_0, e.r1[0]);
                chk("reg_2",   reg2_0, e.r2[0]);
                chk("reg_0_z", reg0_1, e.r0[1]);
                chk("reg_1_z", reg1_1, e.r1[1]);
                chk("reg_2_z", reg2_1, e.r2[1]);
            end
        end
    end

    initial begin
        rst = 1'b0; we = 1'b1; re_a = 1'b1; re_b = 1'b1;
        dir_a = '0; dir_b = '0; dir_wr = '0; di = '0;
        #1 rst = 1'b1;

        cyc(1, 1, 0, 0, 1, 0, 1, 0);
        cyc(1, 1, 0, 0, 1, 0, 1, 0);
        // Initial clear with user traffic that must be ignored.
        for (int i = 0; i < 16; i++) rnd_cyc();

        cyc(0, 0, 5, 32'hDEADBEEF, 1, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 5, 1, 0);
        cyc(0, 0, 7, 32'h11111111, 1, 0, 1, 0);
        cyc(0, 0, 7, 32'h22222222, 0, 7, 0, 7);
        cyc(0, 1, 0, 0, 0, 7, 0, 7);
        cyc(0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 32'h1, 1, 0, 1, 0);
        cyc(0, 0, 1, 32'h2, 1, 0, 1, 0);
        cyc(0, 0, 2, 32'h3, 1, 0, 1, 0);

        for (int i = 0; i < 200; i++) rnd_cyc();
        for (int i = 0; i < 16; i++) cyc(0, 0, 4'(i), 32'hA5A50000 | 32'(i) + 1, 1, 0, 1, 0);

        // Reset in RUN, then again at clear cycle 8, then a full clear.
        cyc(1, 1, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 8; i++) rnd_cyc();
        cyc(1, 0, 3, 32'h12345678, 0, 3, 0, 3);
        for (int i = 0; i < 16; i++) cyc(0, 0, 4'(i), 32'hCAFE0000 | 32'(i), 0, 4'(i), 0, 4'(i));
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 0, 4'(i), 0, 4'(15 - i));

        for (int i = 0; i < 200; i++) rnd_cyc();
        cyc(0, 1, 0, 0, 1, 0, 1, 0);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
